image_filter_stream: RTL

//  Parametrised AXI-Stream 3x3 image filter: buffers incoming raster lines, forms 3x3 windows
//  and applies a runtime-selected kernel (pass/Gaussian/Laplacian), then queues results in an

---
 rtl/image_filter_stream_if.sv | 26 ++
 rtl/image_filter_stream.sv | 204 ++++++++++++++++++++
 2 files changed

// File: rtl/image_filter_stream_if.sv
// Stream bundle for image_filter_stream: pixel input stream, filtered output stream,
// kernel select and line-freed interrupt.
interface image_filter_stream_if #(
    parameter int unsigned DATA_W = 8
);
    logic              i_data_valid;
    logic [DATA_W-1:0] i_data;
    logic              o_data_ready;
    logic              o_data_valid;
    logic [DATA_W-1:0] o_data;
    logic              i_data_ready;
    logic [1:0]        i_mode;
    logic              o_intr;

    // Filter side: consumes pixels, produces filtered pixels
    modport slave (
        input  i_data_valid, i_data, i_data_ready, i_mode,
        output o_data_ready, o_data_valid, o_data, o_intr
    );

    // Environment side (DMA engines or bench)
    modport master (
        output i_data_valid, i_data, i_data_ready, i_mode,
        input  o_data_ready, o_data_valid, o_data, o_intr
    );
endinterface

// File: rtl/image_filter_stream.sv
// 3x3 streaming image filter: four round-robin line buffers, one window per cycle,
// pass / Gaussian / Laplacian kernel, FWFT output FIFO.
// Optional macro IMG_FILTER_ROUND_EN: Gaussian rounds half up instead of truncating.
module image_filter_stream #(
    parameter int unsigned DATA_W     = 8,
    parameter int unsigned IMG_W      = 512,
    parameter int unsigned FIFO_DEPTH = 16
) (
    input  logic                 axi_clk,
    input  logic                 axi_reset_n,
    image_filter_stream_if.slave strm
);
    // Window issue -> FIFO write, in clock edges: window reg, result reg, FIFO write
    localparam int unsigned PIPE_LAT = 3;
    localparam int unsigned COL_W    = (IMG_W > 1) ? $clog2(IMG_W) : 1;
    localparam int unsigned PTR_W    = $clog2(FIFO_DEPTH);
    localparam int unsigned CNT_W    = PTR_W + 1;
    localparam int unsigned OCC_W    = CNT_W + 1;
    localparam int unsigned ACC_W    = DATA_W + 5;
    localparam logic [COL_W-1:0] LAST_COL = COL_W'(IMG_W - 1);
    localparam logic signed [ACC_W-1:0] PIX_MAX = ACC_W'((1 << DATA_W) - 1);

    typedef enum logic [0:0] {StIdle, StRead} state_e;
    state_e state_q, state_d;

    logic [DATA_W-1:0] line_mem [4][IMG_W];
    logic [1:0]        wr_line_q, rd_line_q;
    logic [COL_W-1:0]  wr_col_q, rd_col_q;
    logic [2:0]        filled_q, filled_d;
    logic              rdy_en_q, intr_q;
    logic [1:0]        mode_q;
    logic [PIPE_LAT-2:0] vld_q;
    logic [DATA_W-1:0] win_q [3][3];
    logic [DATA_W-1:0] res_q, result;
    logic [ACC_W-1:0]  g_sum;
    logic signed [ACC_W-1:0] lap;
    logic [COL_W-1:0]  col_w, col_e;

    logic [DATA_W-1:0] fifo_mem [FIFO_DEPTH];
    logic [PTR_W-1:0]  fifo_wr_q, fifo_rd_q;
    logic [CNT_W-1:0]  fifo_cnt_q;
    logic [OCC_W-1:0]  occupancy;

    logic accept, wr_line_done, issue, line_end, room, push, pop;

    // Ready is held low through reset and the first edge after it
    assign strm.o_data_ready = rdy_en_q && (filled_q < 3'd4);
    assign accept            = strm.i_data_valid && strm.o_data_ready;
    assign wr_line_done      = accept && (wr_col_q == LAST_COL);

    // Results already in the pipeline must still find room in the FIFO
    assign occupancy = {1'b0, fifo_cnt_q} + OCC_W'($countones(vld_q));
    assign room      = occupancy < OCC_W'(FIFO_DEPTH);

    // Line buffer storage; only the pointers need clearing
    always_ff @(posedge axi_clk) begin
        if (accept) line_mem[wr_line_q][wr_col_q] <= strm.i_data;
    end

    // Write pointer: column within line, line slot round-robin
    always_ff @(posedge axi_clk or negedge axi_reset_n) begin
        if (!axi_reset_n) begin
            wr_col_q  <= '0;
            wr_line_q <= '0;
        end else if (accept) begin
            if (wr_col_q == LAST_COL) begin
                wr_col_q  <= '0;
                wr_line_q <= wr_line_q + 2'd1;
            end else begin
                wr_col_q <= wr_col_q + 1'b1;
            end
        end
    end

    // Completed-line count; a simultaneous fill and free cancel out
    always_comb begin
        filled_d = filled_q;
        if (wr_line_done && !line_end)      filled_d = filled_q + 3'd1;
        else if (!wr_line_done && line_end) filled_d = filled_q - 3'd1;
    end

    // Read FSM state register
    always_ff @(posedge axi_clk or negedge axi_reset_n) begin
        if (!axi_reset_n) state_q <= StIdle;
        else              state_q <= state_d;
    end

    // Read FSM next state: start once three lines are available
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle:  if (filled_q >= 3'd3) state_d = StRead;
            StRead:  if (line_end) state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    // Read FSM outputs: issue a window whenever the FIFO can absorb it
    always_comb begin
        issue    = 1'b0;
        line_end = 1'b0;
        if (state_q == StRead) begin
            issue    = room;
            line_end = room && (rd_col_q == LAST_COL);
        end
    end

    // Read-side counters, mode latch, interrupt pulse, pipeline valids
    always_ff @(posedge axi_clk or negedge axi_reset_n) begin
        if (!axi_reset_n) begin
            rd_col_q  <= '0;
            rd_line_q <= '0;
            filled_q  <= '0;
            mode_q    <= '0;
            intr_q    <= 1'b0;
            rdy_en_q  <= 1'b0;
            vld_q     <= '0;
        end else begin
            rdy_en_q <= 1'b1;
            filled_q <= filled_d;
            intr_q   <= line_end;
            vld_q    <= {vld_q[0], issue};
            if (state_q == StIdle && state_d == StRead) mode_q <= strm.i_mode;
            if (issue) begin
                if (line_end) begin
                    rd_col_q  <= '0;
                    rd_line_q <= rd_line_q + 2'd1;
                end else begin
                    rd_col_q <= rd_col_q + 1'b1;
                end
            end
        end
    end

    assign strm.o_intr = intr_q;

    // Edge columns are replicated rather than zero-padded
    assign col_w = (rd_col_q == '0) ? rd_col_q : rd_col_q - 1'b1;
    assign col_e = (rd_col_q == LAST_COL) ? rd_col_q : rd_col_q + 1'b1;

    // Window and result datapath registers (qualified by the valid pipeline)
    always_ff @(posedge axi_clk) begin
        if (issue) begin
            for (int r = 0; r < 3; r++) begin
                win_q[r][0] <= line_mem[rd_line_q + 2'(r)][col_w];
                win_q[r][1] <= line_mem[rd_line_q + 2'(r)][rd_col_q];
                win_q[r][2] <= line_mem[rd_line_q + 2'(r)][col_e];
            end
        end
        if (vld_q[0]) res_q <= result;
    end

    // Kernel arithmetic on the captured window
    always_comb begin
        g_sum = ACC_W'(win_q[0][0]) + ACC_W'(win_q[0][2])
              + ACC_W'(win_q[2][0]) + ACC_W'(win_q[2][2])
              + ((ACC_W'(win_q[0][1]) + ACC_W'(win_q[1][0])
                + ACC_W'(win_q[1][2]) + ACC_W'(win_q[2][1])) << 1)
              + (ACC_W'(win_q[1][1]) << 2);
`ifdef IMG_FILTER_ROUND_EN
        g_sum = g_sum + ACC_W'(8);
`else
        g_sum = g_sum;
`endif
        lap = $signed(ACC_W'(win_q[1][1]) << 2)
            - $signed(ACC_W'(win_q[0][1])) - $signed(ACC_W'(win_q[2][1]))
            - $signed(ACC_W'(win_q[1][0])) - $signed(ACC_W'(win_q[1][2]));
        result = win_q[1][1];
        unique case (mode_q)
            2'b01: result = DATA_W'(g_sum >> 4);
            2'b10: begin
                if (lap < 0)             result = '0;
                else if (lap > PIX_MAX)  result = '1;
                else                     result = DATA_W'(lap);
            end
            default: result = win_q[1][1];
        endcase
    end

    assign push = vld_q[1];
    assign pop  = strm.o_data_valid && strm.i_data_ready;

    // Output FIFO storage
    always_ff @(posedge axi_clk) begin
        if (push) fifo_mem[fifo_wr_q] <= res_q;
    end

    // Output FIFO pointers and count
    always_ff @(posedge axi_clk or negedge axi_reset_n) begin
        if (!axi_reset_n) begin
            fifo_wr_q  <= '0;
            fifo_rd_q  <= '0;
            fifo_cnt_q <= '0;
        end else begin
            if (push) fifo_wr_q <= fifo_wr_q + 1'b1;
            if (pop)  fifo_rd_q <= fifo_rd_q + 1'b1;
            if (push && !pop)      fifo_cnt_q <= fifo_cnt_q + 1'b1;
            else if (!push && pop) fifo_cnt_q <= fifo_cnt_q - 1'b1;
        end
    end

    assign strm.o_data_valid = (fifo_cnt_q != '0);
    assign strm.o_data       = strm.o_data_valid ? fifo_mem[fifo_rd_q] : '0;
endmodule
